// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad. Each row is driven low for SCAN_DIV
//   clocks; the synchronized columns are captured at the end of the row slot.
//   After a full scan the 16-bit press map is classified (none / one key /
//   several keys) and a small FSM debounces it over DEBOUNCE_SCANS scans.
//   One keydown pulse is issued per debounced press; no auto-repeat.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   col_n    in   [3:0] keypad columns, active-low, asynchronous
//   row_n    out  [3:0] row drive, active-low one-hot
//   keydown  out  one-clock pulse when a new debounced press is accepted
//   key_id   out  [3:0] last accepted key, 4*row+col; held until next accept
//   key_held out  debounced "accepted key still down" level
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       keydown,
  output logic [3:0] key_id,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_DEB = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_DEB   = 2'd3;

  logic [3:0]       col_s1_q, col_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic [3:0]       row_n_q;
  logic [11:0]      bitmap_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_id_q, key_id_d;
  logic             key_held_q, key_held_d;
  logic             keydown_q;

  logic        row_tick, scan_done;
  logic [3:0]  pressed;
  logic [15:0] scan_map;
  logic [4:0]  n_set;
  logic [3:0]  hit_id;
  logic        found;
  logic        none_hit, one_hit;
  logic        accept, release_done, reached;

  assign row_tick  = (div_q == DIV_LAST);
  assign scan_done = row_tick && (row_q == 2'd3);
  assign pressed   = ~col_s2_q;

  // Row 3 is classified straight from the synchronizer so the decision lands
  // on the same edge that would have stored it.
  assign scan_map = {pressed, bitmap_q};

  always_comb begin
    n_set  = '0;
    hit_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (scan_map[i]) begin
        n_set = n_set + 5'd1;
        if (!found) begin
          hit_id = 4'(i);
          found  = 1'b1;
        end
      end
    end
  end

  assign none_hit = (n_set == 5'd0);
  assign one_hit  = (n_set == 5'd1);
  assign cnt_inc  = cnt_q + CNT_ONE;
  assign reached  = (cnt_inc == CNT_DONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    accept       = 1'b0;
    release_done = 1'b0;
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (one_hit) begin
            cand_d = hit_id;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_PRESS_DEB;
            end
          end
        end
        ST_PRESS_DEB: begin
          if (one_hit && (hit_id == cand_q)) begin
            if (reached) begin
              accept  = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (one_hit) begin
            cand_d = hit_id;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (none_hit) begin
            if (DEBOUNCE_SCANS == 1) begin
              release_done = 1'b1;
              state_d      = ST_IDLE;
              cnt_d        = '0;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_REL_DEB;
            end
          end
        end
        default: begin // ST_REL_DEB
          if (none_hit) begin
            if (reached) begin
              release_done = 1'b1;
              state_d      = ST_IDLE;
              cnt_d        = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    key_id_d   = key_id_q;
    key_held_d = key_held_q;
    if (accept) begin
      key_id_d   = cand_d;
      key_held_d = 1'b1;
    end else if (release_done) begin
      key_held_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q   <= '1;
      col_s2_q   <= '1;
      div_q      <= '0;
      row_q      <= '0;
      row_n_q    <= 4'b1110;
      bitmap_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      key_id_q   <= '0;
      key_held_q <= 1'b0;
      keydown_q  <= 1'b0;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
      if (row_tick) begin
        div_q   <= '0;
        row_q   <= row_q + 2'd1;
        row_n_q <= {row_n_q[2:0], row_n_q[3]};
        case (row_q)
          2'd0:    bitmap_q[3:0]  <= pressed;
          2'd1:    bitmap_q[7:4]  <= pressed;
          2'd2:    bitmap_q[11:8] <= pressed;
          default: ;
        endcase
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      key_id_q   <= key_id_d;
      key_held_q <= key_held_d;
      keydown_q  <= accept;
    end
  end

  assign row_n    = row_n_q;
  assign keydown  = keydown_q;
  assign key_id   = key_id_q;
  assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives a 4x4 key matrix model against keypad_scanner (SCAN_DIV=4,
//   DEBOUNCE_SCANS=3, 16-clock scan). Expected key events are queued when a
//   press is staged and checked when keydown pulses.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       keydown;
  logic [3:0] key_id;
  logic       key_held;

  logic [15:0] keys;

  typedef struct {
    logic [3:0]  id;
    int unsigned cyc;   // 0 = timing not checked
  } exp_t;

  exp_t sb[$];

  int unsigned cyc = 0;
  int unsigned c0  = 0;
  int n_checks = 0;
  int n_errs   = 0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .col_n   (col_n),
    .row_n   (row_n),
    .keydown (keydown),
    .key_id  (key_id),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_n[r] == 1'b0 && keys[4*r+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && keydown === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_keydown", {31'b0, keydown}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("kd_key_id", {28'b0, key_id}, {28'b0, e.id});
        check("kd_key_held", {31'b0, key_held}, 32'd1);
        if (e.cyc != 0) check("kd_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Call from a negedge (or time 0); leaves rst low at a negedge, c0 = cyc.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_row_n", {28'b0, row_n}, 32'hE);
    check("rst_keydown", {31'b0, keydown}, 32'd0);
    check("rst_key_id", {28'b0, key_id}, 32'd0);
    check("rst_key_held", {31'b0, key_held}, 32'd0);
    rst = 1'b0;
    c0  = cyc;
  endtask

  // Wait (at most one scan) for a negedge at a given phase of the scan.
  task automatic align(input int unsigned ph);
    for (int i = 0; i < 16; i++) begin
      if (((cyc - c0) % 16) == ph) break;
      @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    int unsigned rs;
    rst  = 1'b1;
    keys = '0;

    // Reset, row rotation, key(2,1) held from the first scan.
    keys[9] = 1'b1;
    do_reset();
    e.id = 4'd9; e.cyc = c0 + 48; sb.push_back(e);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      rs = ((n + 1) / 4) % 4;
      check("row_rotate", {28'b0, row_n}, (~(32'd1 << rs)) & 32'hF);
    end
    tick(192);
    check("held9", {31'b0, key_held}, 32'd1);
    check("id9", {28'b0, key_id}, 32'd9);

    // Release key 9, then press key(3,2).
    keys = '0;
    tick(16);
    check("rel_not_yet", {31'b0, key_held}, 32'd1);
    tick(64);
    check("rel_held", {31'b0, key_held}, 32'd0);
    check("rel_id_kept", {28'b0, key_id}, 32'd9);
    keys[14] = 1'b1;
    e.id = 4'd14; e.cyc = 0; sb.push_back(e);
    tick(80);
    check("held14", {31'b0, key_held}, 32'd1);
    check("id14", {28'b0, key_id}, 32'd14);
    // One-scan release gap must not produce a new event.
    keys = '0;
    tick(16);
    keys[14] = 1'b1;
    tick(64);
    check("gap_held", {31'b0, key_held}, 32'd1);
    keys = '0;
    tick(80);
    check("rel14_held", {31'b0, key_held}, 32'd0);
    check("rel14_id", {28'b0, key_id}, 32'd14);

    // Bounce on key(0,3); expectation queued only once it is stable.
    align(12);
    keys[3] = 1'b1; tick(7);
    keys[3] = 1'b0; tick(7);
    keys[3] = 1'b1; tick(7);
    keys[3] = 1'b0; tick(7);
    keys[3] = 1'b1; tick(7);
    keys[3] = 1'b0; tick(5);
    keys[3] = 1'b1;
    e.id = 4'd3; e.cyc = 0; sb.push_back(e);
    tick(96);
    check("held3", {31'b0, key_held}, 32'd1);
    check("id3", {28'b0, key_id}, 32'd3);
    keys = '0;
    tick(80);
    check("rel3_held", {31'b0, key_held}, 32'd0);

    // Two keys together: nothing until one is released.
    keys[4]  = 1'b1;
    keys[15] = 1'b1;
    tick(80);
    check("multi_held", {31'b0, key_held}, 32'd0);
    keys[15] = 1'b0;
    e.id = 4'd4; e.cyc = 0; sb.push_back(e);
    tick(80);
    check("held4", {31'b0, key_held}, 32'd1);
    check("id4", {28'b0, key_id}, 32'd4);
    keys = '0;
    tick(80);
    check("rel4_held", {31'b0, key_held}, 32'd0);

    // Key(1,1) pressed right after a scan_done; reset after two scans.
    align(0);
    keys[5] = 1'b1;
    tick(40);
    check("predeb_held", {31'b0, key_held}, 32'd0);
    do_reset();
    e.id = 4'd5; e.cyc = c0 + 48; sb.push_back(e);
    tick(80);
    check("held5", {31'b0, key_held}, 32'd1);
    check("id5", {28'b0, key_id}, 32'd5);

    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
